popcount_window_sum: RTL and testbench
======================================

Name: popcount_window_sum

Overview:
- Downstream consumer of the bit population counter.
- Takes the per-word popcount stream (count + valid) and keeps a running sum of the last DEPTH valid counts in a circular buffer.
- Emits the windowed sum, a window-full flag and a threshold-exceeded flag once per input sample.
- Used for bit-density and link-activity monitoring.

Parameters:
- WIDTH, 32, data width of the upstream popcount source; the count input is CNT_W = $clog2(WIDTH)+1 bits.
- DEPTH, 16, window length in valid samples; any integer >= 2, not required to be a power of two.
- SUM_W, $clog2(WIDTH*DEPTH+1), derived localparam; the sum width, which holds WIDTH*DEPTH without overflow.

Ports:
- clk_i  in  1  single clock.
- srst_i  in  1  synchronous reset, active-high.
- cnt_i  in  CNT_W  popcount of one word, legal range 0..WIDTH.
- cnt_val_i  in  1  cnt_i valid qualifier, may be asserted every cycle.
- clear_i  in  1  synchronous window flush.
- thresh_i  in  SUM_W  threshold, sampled together with each valid sample.
- sum_o  out  SUM_W  sum of the last min(fill, DEPTH) valid counts.
- sum_val_o  out  1  one-cycle strobe per accepted sample.
- full_o  out  1  window holds DEPTH samples.
- over_o  out  1  sum_o >= thresh_i, with thresh_i as sampled with that sample.

Behaviour:
- Interface: one clock, clk_i. Reset is srst_i, synchronous and active-high. All outputs are registered.
- Reset: on the cycle after srst_i is high:
  - sum_o=0, sum_val_o=0, full_o=0, over_o=0.
  - Write pointer = 0, fill count = 0.
  - All buffer entries read as 0. The implementation may either clear the array or gate the subtracted value with the fill count.
  - srst_i overrides clear_i and cnt_val_i.
- Storage: DEPTH x CNT_W circular buffer, write pointer wr_ptr in 0..DEPTH-1, fill count in 0..DEPTH (saturating).
- Accepted sample (cnt_val_i=1, clear_i=0):
  - old = buf[wr_ptr], or 0 if that slot has not been written since the last reset/clear.
  - sum_next = sum_o + cnt_i - old. Computed at SUM_W width; no saturation is needed and no intermediate may underflow.
  - buf[wr_ptr] <= cnt_i.
  - wr_ptr wraps DEPTH-1 -> 0.
  - fill increments, saturating at DEPTH.
- Latency: 1 cycle. sum_o, full_o and over_o update, and sum_val_o pulses, on the edge after the cycle in which cnt_val_i=1.
- Idle cycles (cnt_val_i=0): sum_val_o=0. sum_o, full_o and over_o hold their last values. Gaps in valid do not age the window; the window counts samples, not cycles.
- full_o: set together with the sum_val_o of the DEPTH-th sample after reset/clear, and stays set until the next reset or clear.
- over_o: registered result of sum_next >= thresh_i, evaluated only on accepted samples. thresh_i changes between samples have no effect until the next sample.
- clear_i=1 with cnt_val_i=0:
  - Next cycle: sum_o=0, fill=0, full_o=0, over_o=0, wr_ptr=0, sum_val_o=0.
  - Buffer contents are logically zeroed.
- clear_i=1 with cnt_val_i=1 in the same cycle:
  - The clear is applied first; the sample becomes the first of the new window.
  - Next cycle: sum_o=cnt_i, fill=1, wr_ptr=1, sum_val_o=1, full_o=0 (full_o=1 only if DEPTH would be 1, which is disallowed).
  - over_o = (cnt_i >= thresh_i).
- Values of cnt_i > WIDTH are never produced upstream; no checking is done and behaviour is undefined.
- Reset mid-window: all state is discarded. The first sample after reset yields sum_o = that sample.

Test Plan:
- DEPTH=4, WIDTH=32, reset then samples 5,7,1,3 back-to-back -> sum_o 5,12,13,16 on consecutive cycles, each with sum_val_o=1; full_o=1 only with the sum of 16.
- Continue with 10,0,32 -> sum_o 21,14,45 (oldest values 5,7,1 are dropped); wrap-around verified.
- Same as above with 3 idle cycles between samples -> identical sum_o sequence; sum_val_o only on the sample cycles; outputs hold during the gaps.
- thresh_i=20 throughout the first two scenarios -> over_o=0 for 5,12,13,16; over_o=1 for 21; 0 for 14; 1 for 45. Changing thresh_i to 0 mid-gap does not alter over_o until the next sample.
- Full window, then clear_i and cnt_val_i together with cnt_i=9, thresh_i=9 -> sum_o=9, full_o=0, over_o=1. Then three more samples of 9 -> sum_o 18,27,36, full_o=1 at 36.
- srst_i asserted mid-stream with cnt_val_i=1 -> next cycle all outputs 0 and no sum_val_o. A post-reset sample of 4 yields sum_o=4, confirming the buffer was zeroed.

Source files
------------

// File: rtl/popcount_window_sum_if.sv
// rtl/popcount_window_sum_if.sv - popcount sample in / windowed sum out bundle
interface popcount_window_sum_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int SUM_W = $clog2(WIDTH * DEPTH + 1);

    logic [CNT_W-1:0] cnt_i;
    logic             cnt_val_i;
    logic             clear_i;
    logic [SUM_W-1:0] thresh_i;
    logic [SUM_W-1:0] sum_o;
    logic             sum_val_o;
    logic             full_o;
    logic             over_o;

    modport master (
        output cnt_i, cnt_val_i, clear_i, thresh_i,
        input  sum_o, sum_val_o, full_o, over_o
    );

    modport slave (
        input  cnt_i, cnt_val_i, clear_i, thresh_i,
        output sum_o, sum_val_o, full_o, over_o
    );
endinterface

// File: rtl/popcount_window_sum.sv
// rtl/popcount_window_sum.sv - running sum of the last DEPTH popcount samples
module popcount_window_sum #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                 clk_i,
    input  logic                 srst_i,
    popcount_window_sum_if.slave bus
);
    localparam int CNT_W  = $clog2(WIDTH) + 1;
    localparam int SUM_W  = $clog2(WIDTH * DEPTH + 1);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0]  PTR_MAX  = PTR_W'(DEPTH - 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

    logic [CNT_W-1:0]  buf_q [DEPTH];
    logic [CNT_W-1:0]  buf_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic              sum_val_q, sum_val_d;
    logic              full_q, full_d;
    logic              over_q, over_d;

    logic [PTR_W-1:0]  base_ptr;
    logic [FILL_W-1:0] base_fill;
    logic [SUM_W-1:0]  base_sum;
    logic [CNT_W-1:0]  old_cnt;
    logic [SUM_W-1:0]  sum_next;

    always_comb begin
        buf_d     = buf_q;
        wr_ptr_d  = wr_ptr_q;
        fill_d    = fill_q;
        sum_d     = sum_q;
        sum_val_d = 1'b0;
        full_d    = full_q;
        over_d    = over_q;

        // A clear rebases the window so a same-cycle sample starts it afresh.
        base_ptr  = bus.clear_i ? '0 : wr_ptr_q;
        base_fill = bus.clear_i ? '0 : fill_q;
        base_sum  = bus.clear_i ? '0 : sum_q;

        // Until the window has wrapped, the slot under wr_ptr is stale and counts as zero.
        old_cnt  = (base_fill == FILL_MAX) ? buf_q[base_ptr] : '0;
        // old_cnt is already part of base_sum, so subtracting first cannot underflow.
        sum_next = (base_sum - SUM_W'(old_cnt)) + SUM_W'(bus.cnt_i);

        if (bus.clear_i) begin
            wr_ptr_d = '0;
            fill_d   = '0;
            sum_d    = '0;
            full_d   = 1'b0;
            over_d   = 1'b0;
        end

        if (bus.cnt_val_i) begin
            buf_d[base_ptr] = bus.cnt_i;
            wr_ptr_d        = (base_ptr == PTR_MAX) ? '0 : base_ptr + PTR_W'(1);
            fill_d          = (base_fill == FILL_MAX) ? base_fill : base_fill + FILL_W'(1);
            sum_d           = sum_next;
            sum_val_d       = 1'b1;
            full_d          = (fill_d == FILL_MAX);
            over_d          = (sum_next >= bus.thresh_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wr_ptr_q  <= '0;
            fill_q    <= '0;
            sum_q     <= '0;
            sum_val_q <= 1'b0;
            full_q    <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            fill_q    <= fill_d;
            sum_q     <= sum_d;
            sum_val_q <= sum_val_d;
            full_q    <= full_d;
            over_q    <= over_d;
        end
    end

    // Entries need no reset: fill_q gates every read of a stale slot.
    always_ff @(posedge clk_i) begin
        buf_q <= buf_d;
    end

    assign bus.sum_o     = sum_q;
    assign bus.sum_val_o = sum_val_q;
    assign bus.full_o    = full_q;
    assign bus.over_o    = over_q;
endmodule

// File: tb/tb_popcount_window_sum.sv
// tb/tb_popcount_window_sum.sv - scoreboard bench for popcount_window_sum
module tb_popcount_window_sum;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    typedef struct {
        int sum;
        bit full;
        bit over;
    } exp_t;

    logic clk;
    logic srst;
    int   total;
    int   bad;
    exp_t sb[$];
    int   win[$];
    int   last_sum;
    bit   last_full;
    bit   last_over;

    popcount_window_sum_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    popcount_window_sum #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i  (clk),
        .srst_i (srst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.sum_val_o === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_sum_val: got sum=%0d with no sample pending", bus.sum_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                total++;
                if (bus.sum_o !== 8'(e.sum)) begin
                    bad++;
                    $display("FAIL sum: got %0d expected %0d", bus.sum_o, e.sum);
                end
                total++;
                if (bus.full_o !== e.full) begin
                    bad++;
                    $display("FAIL full: got %b expected %b (sum %0d)", bus.full_o, e.full, e.sum);
                end
                total++;
                if (bus.over_o !== e.over) begin
                    bad++;
                    $display("FAIL over: got %b expected %b (sum %0d)", bus.over_o, e.over, e.sum);
                end
            end
        end
    end

    task automatic model_clear();
        win.delete();
        last_sum  = 0;
        last_full = 0;
        last_over = 0;
    endtask

    task automatic drive_sample(input int c, input int thr, input bit clr);
        exp_t e;
        int   s;
        if (clr) win.delete();
        win.push_back(c);
        if (win.size() > DEPTH) void'(win.pop_front());
        s = 0;
        foreach (win[i]) s += win[i];
        e.sum  = s;
        e.full = (win.size() == DEPTH);
        e.over = (s >= thr);
        sb.push_back(e);
        last_sum  = e.sum;
        last_full = e.full;
        last_over = e.over;
        bus.cnt_i     = 6'(c);
        bus.thresh_i  = 8'(thr);
        bus.clear_i   = clr;
        bus.cnt_val_i = 1'b1;
        @(posedge clk); #1;
        bus.cnt_val_i = 1'b0;
        bus.clear_i   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i > 0) begin
                total++;
                if (bus.sum_val_o !== 1'b0 || bus.sum_o !== 8'(last_sum) ||
                    bus.full_o !== last_full || bus.over_o !== last_over) begin
                    bad++;
                    $display("FAIL idle_hold: got val=%b sum=%0d full=%b over=%b expected val=0 sum=%0d full=%b over=%b",
                             bus.sum_val_o, bus.sum_o, bus.full_o, bus.over_o, last_sum, last_full, last_over);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic check_zero(input string name);
        @(negedge clk);
        total++;
        if (bus.sum_o !== 8'd0 || bus.sum_val_o !== 1'b0 || bus.full_o !== 1'b0 || bus.over_o !== 1'b0) begin
            bad++;
            $display("FAIL %s: got sum=%0d val=%b full=%b over=%b expected all 0",
                     name, bus.sum_o, bus.sum_val_o, bus.full_o, bus.over_o);
        end
    endtask

    task automatic pulse_reset(input bit with_sample);
        srst          = 1'b1;
        bus.cnt_val_i = with_sample;
        bus.cnt_i     = 6'd17;
        @(posedge clk); #1;
        srst          = 1'b0;
        bus.cnt_val_i = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        srst          = 1'b1;
        bus.cnt_i     = '0;
        bus.cnt_val_i = 1'b0;
        bus.clear_i   = 1'b0;
        bus.thresh_i  = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        srst = 1'b0;
        check_zero("reset_state");
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int seq[7] = '{5, 7, 1, 3, 10, 0, 32};
        foreach (seq[i]) drive_sample(seq[i], 20, 1'b0);
        idle(2);
    endtask

    task automatic test_gaps();
        int seq[7] = '{5, 7, 1, 3, 10, 0, 32};
        pulse_reset(1'b0);
        foreach (seq[i]) begin
            drive_sample(seq[i], 20, 1'b0);
            if (i == 5) bus.thresh_i = 8'd0;
            idle(4);
        end
    endtask

    task automatic test_clear_with_sample();
        drive_sample(9, 9, 1'b1);
        for (int i = 0; i < 3; i++) drive_sample(9, 9, 1'b0);
        idle(2);
    endtask

    task automatic test_clear_only();
        bus.clear_i = 1'b1;
        @(posedge clk); #1;
        bus.clear_i = 1'b0;
        model_clear();
        check_zero("clear_only");
        @(posedge clk); #1;
        drive_sample(6, 100, 1'b0);
        idle(2);
    endtask

    task automatic test_reset_mid();
        drive_sample(30, 10, 1'b0);
        drive_sample(31, 10, 1'b0);
        pulse_reset(1'b1);
        check_zero("reset_mid_stream");
        @(posedge clk); #1;
        drive_sample(4, 3, 1'b0);
        idle(2);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            drive_sample($urandom_range(0, WIDTH), $urandom_range(0, WIDTH * DEPTH),
                         ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(2);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        srst  = 1'b1;
        test_reset();
        test_back_to_back();
        test_gaps();
        test_clear_with_sample();
        test_clear_only();
        test_reset_mid();
        test_random();
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expected results never produced, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
